// File: rtl/prog_moore_fsm.sv
// Table-driven Moore FSM: next-state and output tables are loaded through a config port, then stepped while run=1.
// Optional expected-output comparator and mismatch counter are built only when FSM_EXP_CHECK_EN is defined.
module prog_moore_fsm #(
  parameter int NUM_STATES  = 8,
  parameter int STATE_W     = 3,
  parameter int IN_W        = 2,
  parameter int OUT_W       = 4,
  parameter int RESET_STATE = 0
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          cfg_we,
  input  logic                                          cfg_sel,
  input  logic [STATE_W+IN_W-1:0]                       cfg_addr,
  input  logic [((STATE_W > OUT_W) ? STATE_W : OUT_W)-1:0] cfg_data,
  input  logic                                          run,
  input  logic                                          restart,
  input  logic [IN_W-1:0]                               in,
  input  logic [OUT_W-1:0]                              exp_out,
  output logic [STATE_W-1:0]                            state,
  output logic [OUT_W-1:0]                              out,
  output logic                                          cfg_err,
  output logic                                          illegal,
  output logic                                          mismatch,
  output logic [7:0]                                    mismatch_cnt
);

  localparam int AW = STATE_W + IN_W;
  localparam logic [STATE_W-1:0] RST_S = STATE_W'(RESET_STATE);

  typedef enum logic {IDLE, STEP} mode_t;

  mode_t              mode;
  logic [STATE_W-1:0] ns_table  [2**AW];
  logic [OUT_W-1:0]   out_table [2**STATE_W];
  logic [STATE_W-1:0] state_nxt;
  logic [STATE_W-1:0] lookup;
  logic               illegal_hit;
  logic               addr_ok;
  logic               cfg_ok;
  logic               cfg_bad;

  always_comb mode = run ? STEP : IDLE;

  // Tables are sized to full power-of-two depth; rows at or above NUM_STATES are never written.
  always_comb begin
    addr_ok = 32'(cfg_addr[AW-1:IN_W]) < NUM_STATES;
    cfg_ok  = 1'b0;
    cfg_bad = 1'b0;
    if (cfg_we) begin
      if (mode == IDLE && addr_ok) cfg_ok  = 1'b1;
      else                         cfg_bad = 1'b1;
    end
  end

  always_comb begin
    lookup      = ns_table[{state, in}];
    state_nxt   = state;
    illegal_hit = 1'b0;
    if (restart) begin
      state_nxt = RST_S;
    end else begin
      case (mode)
        STEP: begin
          if (32'(lookup) < NUM_STATES) state_nxt   = lookup;
          else                          illegal_hit = 1'b1;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RST_S;
      cfg_err <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cfg_bad)     cfg_err <= 1'b1;
      if (illegal_hit) illegal <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 2**AW; i++)      ns_table[i]  <= RST_S;
      for (int unsigned i = 0; i < 2**STATE_W; i++) out_table[i] <= '0;
    end else if (cfg_ok) begin
      if (cfg_sel) out_table[cfg_addr[AW-1:IN_W]] <= cfg_data[OUT_W-1:0];
      else         ns_table[cfg_addr]             <= cfg_data[STATE_W-1:0];
    end
  end

  always_comb out = out_table[state];

`ifdef FSM_EXP_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mismatch     <= 1'b0;
      mismatch_cnt <= '0;
    end else if (mode == STEP && out != exp_out) begin
      mismatch <= 1'b1;
      if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 8'd1;
    end
  end
`else
  logic unused_exp;
  always_comb begin
    mismatch     = 1'b0;
    mismatch_cnt = '0;
    unused_exp   = ^exp_out;
  end
`endif

endmodule

// File: tb/tb_prog_moore_fsm.sv
// Self-checking bench for prog_moore_fsm (NUM_STATES=6): directed table, corner sequences, random vs reference model.
module tb_prog_moore_fsm;
  localparam int NS = 6;
  localparam int IW = 2;

  logic       clk = 1'b0;
  logic       reset, cfg_we, cfg_sel, run, restart;
  logic [4:0] cfg_addr;
  logic [3:0] cfg_data, exp_out, out;
  logic [1:0] in;
  logic [2:0] state;
  logic       cfg_err, illegal, mismatch;
  logic [7:0] mismatch_cnt;

  always #5 clk = ~clk;

  prog_moore_fsm #(.NUM_STATES(NS), .STATE_W(3), .IN_W(2), .OUT_W(4), .RESET_STATE(0)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .run(run), .restart(restart), .in(in), .exp_out(exp_out),
    .state(state), .out(out), .cfg_err(cfg_err), .illegal(illegal), .mismatch(mismatch),
    .mismatch_cnt(mismatch_cnt)
  );

`ifdef FSM_EXP_CHECK_EN
  localparam bit MM_ON = 1'b1;
`else
  localparam bit MM_ON = 1'b0;
`endif

  // Reference model: plain arrays indexed by state and input symbol.
  int m_ns [8][4];
  int m_out[8];
  int m_st, m_cnt;
  bit m_err, m_ill, m_mm;
  int checks, failures;

  typedef struct {
    bit       run;
    bit       restart;
    int       in;
    int       exp_out;
    int       st;
    int       o;
  } vec_t;
  vec_t vt[8];

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      m_out[s] = 0;
      for (int i = 0; i < 4; i++) m_ns[s][i] = 0;
    end
    m_st = 0; m_cnt = 0; m_err = 0; m_ill = 0; m_mm = 0;
  endtask

  task automatic model_edge();
    int s, n;
    if (cfg_we) begin
      s = int'(cfg_addr) >> IW;
      if (run || s >= NS) m_err = 1;
      else if (cfg_sel)   m_out[s] = int'(cfg_data);
      else                m_ns[s][int'(cfg_addr) % 4] = int'(cfg_data) % 8;
    end
    if (MM_ON && run && m_out[m_st] != int'(exp_out)) begin
      m_mm = 1;
      if (m_cnt < 255) m_cnt++;
    end
    if (restart) m_st = 0;
    else if (run) begin
      n = m_ns[m_st][in];
      if (n < NS) m_st = n;
      else        m_ill = 1;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},        32'(state),        32'(m_st));
    chk({tag, ".out"},          32'(out),          32'(m_out[m_st]));
    chk({tag, ".cfg_err"},      32'(cfg_err),      32'(m_err));
    chk({tag, ".illegal"},      32'(illegal),      32'(m_ill));
    chk({tag, ".mismatch"},     32'(mismatch),     32'(m_mm));
    chk({tag, ".mismatch_cnt"}, 32'(mismatch_cnt), 32'(m_cnt));
  endtask

  task automatic drive(input bit we, input bit sel, input int addr, input int data,
                       input bit r, input bit rs, input int i, input int e);
    cfg_we = we; cfg_sel = sel; cfg_addr = 5'(addr); cfg_data = 4'(data);
    run = r; restart = rs; in = 2'(i); exp_out = 4'(e);
  endtask

  task automatic cfg_write(input bit sel, input int s, input int idx, input int data);
    drive(1, sel, (s << 2) | idx, data, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_all("cfg_write");
  endtask

  // Run one step with exp_out matching the model's current output.
  task automatic step(input bit r, input bit rs, input int i);
    drive(0, 0, 0, 0, r, rs, i, m_out[m_st]);
    tick();
  endtask

  initial begin
    checks = 0; failures = 0;
    vt[0] = '{1, 0, 1, 1, 1, 2};
    vt[1] = '{1, 0, 1, 2, 2, 4};
    vt[2] = '{1, 0, 1, 4, 0, 1};
    vt[3] = '{1, 0, 1, 1, 1, 2};
    vt[4] = '{1, 0, 0, 2, 1, 2};
    vt[5] = '{1, 0, 3, 2, 1, 2};
    vt[6] = '{0, 0, 1, 2, 1, 2};
    vt[7] = '{1, 1, 1, 2, 0, 1};

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(posedge clk); #1;
    reset = 1'b1;

    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 1, 0, $urandom_range(0, 3), 0);
      tick();
      chk("empty_table.state", 32'(state), 0);
      check_all("empty_table");
    end

    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 4; i++)
        cfg_write(0, s, i, (i == 1) ? (s + 1) % 3 : s);
    cfg_write(1, 0, 0, 1);
    cfg_write(1, 1, 0, 2);
    cfg_write(1, 2, 0, 4);

    for (int v = 0; v < 8; v++) begin
      drive(0, 0, 0, 0, vt[v].run, vt[v].restart, vt[v].in, vt[v].exp_out);
      tick();
      chk($sformatf("ring[%0d].state", v), 32'(state), 32'(vt[v].st));
      chk($sformatf("ring[%0d].out", v),   32'(out),   32'(vt[v].o));
      check_all("ring");
    end

    cfg_write(1, NS - 1, 0, 9);
    chk("cfg_last_state.cfg_err", 32'(cfg_err), 0);
    cfg_write(0, NS, 1, 3);
    chk("cfg_bad_addr.cfg_err", 32'(cfg_err), 1);
    drive(1, 0, (0 << 2) | 1, 3, 1, 0, 1, 1);
    tick();
    check_all("cfg_during_run");
    step(0, 1, 0);
    step(1, 0, 1);
    chk("no_write_when_run.state", 32'(state), 1);
    check_all("no_write_when_run");

    cfg_write(0, 2, 0, 7);
    step(1, 0, 1);
    chk("reach2.state", 32'(state), 2);
    step(1, 1, 0);
    chk("restart_beats_illegal.state", 32'(state), 0);
    chk("restart_beats_illegal.illegal", 32'(illegal), 0);
    step(1, 0, 1);
    step(1, 0, 1);
    step(1, 0, 0);
    chk("illegal_hold.state", 32'(state), 2);
    chk("illegal_hold.illegal", 32'(illegal), 1);
    step(0, 1, 0);
    chk("restart_sticky.state", 32'(state), 0);
    chk("restart_sticky.illegal", 32'(illegal), 1);
    check_all("restart_sticky");

    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 1, 0, 0, 4'hE);
      tick();
    end
    chk("mismatch3.flag", 32'(mismatch),     MM_ON ? 1 : 0);
    chk("mismatch3.cnt",  32'(mismatch_cnt), MM_ON ? 3 : 0);
    for (int k = 0; k < 300; k++) begin
      drive(0, 0, 0, 0, 1, 0, 0, 4'hE);
      tick();
    end
    chk("mismatch_sat.cnt", 32'(mismatch_cnt), MM_ON ? 255 : 0);
    check_all("mismatch_sat");

    step(1, 0, 1);
    step(1, 0, 1);
    chk("pre_reset.state", 32'(state), 2);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    chk("async_reset.state", 32'(state), 0);
    chk("async_reset.out",   32'(out),   0);
    check_all("async_reset");
    @(posedge clk); #1;
    check_all("reset_held");
    reset = 1'b1;
    step(1, 0, 1);
    chk("tables_cleared.state", 32'(state), 0);
    check_all("tables_cleared");

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0)
        drive(1, 1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom_range(0, 15),
              $urandom_range(0, 7) == 0, 0, $urandom_range(0, 3), m_out[m_st]);
      else
        drive(0, 0, 0, 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : m_out[m_st]);
      tick();
      check_all("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
